regfile_sequencer: RTL and testbench

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_sequencer.sv | 131 +++++++++++++
 tb/tb_regfile_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Command sequencer in front of an external 8x16 register file: single-cycle
// WRITE, READ with a held response handshake, and an 8-cycle CLEAR sweep.
module regfile_sequencer #(
  parameter logic [15:0] CLEAR_VALUE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [2:0]  cmd_aa_i,
  input  logic [2:0]  cmd_ba_i,
  input  logic [2:0]  cmd_da_i,
  input  logic [15:0] cmd_d_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_a_o,
  output logic [15:0] rsp_b_o,
  output logic [2:0]  aa_o,
  output logic [2:0]  ba_o,
  output logic [2:0]  da_o,
  output logic [15:0] d_o,
  output logic        wr_o,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP,
    S_CLEAR
  } state_e;

  state_e      state_q, state_d;
  logic        accept;
  logic [2:0]  cnt_q;
  logic [2:0]  aa_q, ba_q, da_q;
  logic [15:0] d_q;
  logic [15:0] rsp_a_q, rsp_b_q;

  assign accept = cmd_valid_i && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op_i)
            2'b00:   state_d = S_WRITE;
            2'b01:   state_d = S_READ;
            2'b10:   state_d = S_CLEAR;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_READ:  state_d = S_RESP;
      S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
      S_CLEAR: if (cnt_q == 3'd7) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = 1'b0;
    wr_o        = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      S_WRITE: wr_o        = 1'b1;
      S_CLEAR: wr_o        = 1'b1;
      S_RESP:  rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // CLEAR reuses the write-address/data registers: da_q tracks cnt_q one step
  // ahead so the address presented during each CLEAR cycle equals the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      aa_q    <= '0;
      ba_q    <= '0;
      da_q    <= '0;
      d_q     <= '0;
      rsp_a_q <= '0;
      rsp_b_q <= '0;
    end else begin
      if (accept) begin
        aa_q <= cmd_aa_i;
        ba_q <= cmd_ba_i;
        if (cmd_op_i == 2'b10) begin
          da_q  <= '0;
          d_q   <= CLEAR_VALUE;
          cnt_q <= '0;
        end else begin
          da_q <= cmd_da_i;
          d_q  <= cmd_d_i;
        end
      end
      if (state_q == S_CLEAR) begin
        cnt_q <= cnt_q + 3'd1;
        da_q  <= cnt_q + 3'd1;
      end
      if (state_q == S_READ) begin
        rsp_a_q <= a_i;
        rsp_b_q <= b_i;
      end
    end
  end

  assign aa_o    = aa_q;
  assign ba_o    = ba_q;
  assign da_o    = da_q;
  assign d_o     = d_q;
  assign rsp_a_o = rsp_a_q;
  assign rsp_b_o = rsp_b_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: hosts the 8x16 register file, applies a vector
// table, multi-cycle corner sequences and a random stream against a model.
module tb_regfile_sequencer;

  localparam logic [15:0] CLR = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_aa, cmd_ba, cmd_da;
  logic [15:0] cmd_d;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_a, rsp_b;
  logic [2:0]  aa, ba, da;
  logic [15:0] d, a, b;
  logic        wr, busy;

  logic [15:0] rf    [8];
  logic [15:0] model [8];

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (wr) rf[da] <= d;
  assign a = rf[aa];
  assign b = rf[ba];

  regfile_sequencer #(.CLEAR_VALUE(CLR)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_aa_i(cmd_aa), .cmd_ba_i(cmd_ba), .cmd_da_i(cmd_da), .cmd_d_i(cmd_d),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_a_o(rsp_a), .rsp_b_o(rsp_b),
    .aa_o(aa), .ba_o(ba), .da_o(da), .d_o(d), .wr_o(wr),
    .a_i(a), .b_i(b), .busy_o(busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  aa, ba, da;
    logic [15:0] d, ea, eb;
  } vec_t;

  vec_t vt [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // All tasks start and end just after a falling edge.
  task automatic send(input logic [1:0] op, input logic [2:0] xa, input logic [2:0] xb,
                      input logic [2:0] xd, input logic [15:0] xdata);
    int unsigned n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op;
    cmd_aa = xa; cmd_ba = xb; cmd_da = xd; cmd_d = xdata;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] xd, input logic [15:0] xdata);
    send(2'b00, 3'd0, 3'd0, xd, xdata);
    check("write_wr", {31'd0, wr}, 32'd1);
    check("write_da", {29'd0, da}, {29'd0, xd});
    check("write_d", {16'd0, d}, {16'd0, xdata});
    check("write_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("write_wr_drop", {31'd0, wr}, 32'd0);
    model[xd] = xdata;
  endtask

  task automatic do_read(input logic [2:0] xa, input logic [2:0] xb, input int unsigned hold,
                         input bit poke, output logic [15:0] ra, output logic [15:0] rb);
    send(2'b01, xa, xb, 3'd0, 16'd0);
    check("read_wr", {31'd0, wr}, 32'd0);
    check("read_aa", {26'd0, aa, ba}, {26'd0, xa, xb});
    @(negedge clk);
    check("resp_valid", {31'd0, rsp_valid}, 32'd1);
    ra = rsp_a;
    rb = rsp_b;
    for (int unsigned i = 0; i < hold; i++) begin
      if (poke) begin
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_da = xa; cmd_d = 16'hDEAD;
      end
      @(negedge clk);
      check("resp_hold_valid", {30'd0, rsp_valid, cmd_ready}, 32'd2);
      check("resp_hold_data", {rsp_a, rsp_b}, {ra, rb});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("resp_done", {30'd0, rsp_valid, cmd_ready}, 32'd1);
  endtask

  task automatic read_check(input logic [2:0] xa, input logic [2:0] xb, input int unsigned hold);
    logic [15:0] ra, rb;
    do_read(xa, xb, hold, 1'b0, ra, rb);
    check("read_a", {16'd0, ra}, {16'd0, model[xa]});
    check("read_b", {16'd0, rb}, {16'd0, model[xb]});
  endtask

  task automatic do_clear();
    send(2'b10, 3'd0, 3'd0, 3'd5, 16'h1234);
    for (int unsigned i = 0; i < 8; i++) begin
      check("clear_wr", {30'd0, wr, busy}, 32'd3);
      check("clear_da", {29'd0, da}, i);
      check("clear_d", {16'd0, d}, {16'd0, CLR});
      @(negedge clk);
    end
    check("clear_end", {29'd0, wr, busy, cmd_ready}, 32'd1);
    for (int unsigned i = 0; i < 8; i++) model[i] = CLR;
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_aa = '0; cmd_ba = '0; cmd_da = '0; cmd_d = '0;

    vt[0] = '{2'b00, 3'd0, 3'd0, 3'd3, 16'hA5A5, 16'h0, 16'h0};
    vt[1] = '{2'b01, 3'd3, 3'd0, 3'd0, 16'h0, 16'hA5A5, 16'h0000};
    vt[2] = '{2'b00, 3'd0, 3'd0, 3'd1, 16'h1111, 16'h0, 16'h0};
    vt[3] = '{2'b00, 3'd0, 3'd0, 3'd7, 16'hFFFF, 16'h0, 16'h0};
    vt[4] = '{2'b01, 3'd7, 3'd1, 3'd0, 16'h0, 16'hFFFF, 16'h1111};
    vt[5] = '{2'b00, 3'd0, 3'd0, 3'd0, 16'h8001, 16'h0, 16'h0};
    vt[6] = '{2'b01, 3'd0, 3'd3, 3'd0, 16'h0, 16'h8001, 16'hA5A5};
    vt[7] = '{2'b00, 3'd0, 3'd0, 3'd3, 16'h0000, 16'h0, 16'h0};
    vt[8] = '{2'b01, 3'd3, 3'd7, 3'd0, 16'h0, 16'h0000, 16'hFFFF};

    #2;
    check("reset_ctrl", {28'd0, wr, rsp_valid, busy, cmd_ready}, 32'd1);
    check("reset_addr", {23'd0, aa, ba, da}, 32'd0);
    check("reset_data", {d, rsp_a | rsp_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_reset_ready", {30'd0, cmd_ready, busy}, 32'd2);

    do_clear();

    for (int unsigned i = 0; i < 9; i++) begin
      if (vt[i].op == 2'b00) begin
        do_write(vt[i].da, vt[i].d);
      end else begin
        do_read(vt[i].aa, vt[i].ba, 3, 1'b0, ra, rb);
        check("vec_a", {16'd0, ra}, {16'd0, vt[i].ea});
        check("vec_b", {16'd0, rb}, {16'd0, vt[i].eb});
      end
    end

    for (int unsigned i = 0; i < 8; i++) do_write(3'(i), 16'hC000 + 16'(i));
    do_clear();
    for (int unsigned i = 0; i < 8; i += 2) read_check(3'(i), 3'(i + 1), 0);

    do_write(3'd5, 16'hBEEF);
    do_write(3'd2, 16'h1234);
    do_read(3'd5, 3'd2, 10, 1'b1, ra, rb);
    check("stall_a", {16'd0, ra}, 32'h0000BEEF);
    check("stall_b", {16'd0, rb}, 32'h00001234);
    read_check(3'd5, 3'd5, 0);

    send(2'b11, 3'd1, 3'd2, 3'd4, 16'h7777);
    check("reserved_idle", {29'd0, wr, busy, cmd_ready}, 32'd1);
    @(negedge clk);
    check("reserved_after", {29'd0, wr, busy, cmd_ready}, 32'd1);
    read_check(3'd4, 3'd4, 0);

    for (int unsigned i = 0; i < 8; i++) do_write(3'(i), 16'h0100 + 16'(i));
    send(2'b10, 3'd0, 3'd0, 3'd0, 16'h0);
    for (int unsigned i = 0; i < 4; i++) @(negedge clk);
    check("abort_at_4", {28'd0, wr, da}, 32'd12);
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", {29'd0, wr, busy, rsp_valid}, 32'd0);
    check("abort_da", {29'd0, da}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_ready", {30'd0, cmd_ready, busy}, 32'd2);
    @(negedge clk);
    for (int unsigned i = 0; i < 4; i++) model[i] = CLR;
    for (int unsigned i = 0; i < 8; i += 2) read_check(3'(i), 3'(i + 1), 0);

    send(2'b01, 3'd7, 3'd6, 3'd0, 16'h0);
    @(negedge clk);
    check("resp_before_rst", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("resp_rst_drop", {15'd0, rsp_valid, rsp_a | rsp_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("resp_rst_idle", {30'd0, cmd_ready, rsp_valid}, 32'd2);

    for (int unsigned n = 0; n < 200; n++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(3'($urandom_range(0, 7)), 16'($urandom));
      else
        read_check(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
